// File: rtl/burst_ram_arbiter_if.sv
// BurstRAM-style port bundle. One instance per cache port and one for the RAM side.
//
// Handshake: there is no valid/ready pair. The issuer samples busy. While busy is low
// it may pulse cmd_en for one cycle together with cmd/addr and write beat 0.
// A write then streams the remaining beats on wr_data/data_mask on consecutive
// cycles. A read returns its beats on rd_data, with each beat qualified by
// rd_data_valid. Nothing is buffered, so a cmd_en that is not accepted is simply
// dropped.
interface burst_ram_arbiter_if #(
    parameter int RAM_DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH      = 64
);
    logic                         cmd;        // 0 = read burst, 1 = write burst
    logic                         cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0] addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;
    logic [DATA_BITWIDTH/8-1:0]   data_mask;  // 1 = byte written
    logic [DATA_BITWIDTH-1:0]     rd_data;
    logic                         rd_data_valid;
    logic                         busy;

    // Side that issues bursts (a cache, or the arbiter towards the RAM)
    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    // Side that serves bursts (the arbiter towards a cache, or the RAM)
    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-master time-sliced arbiter in front of one BurstRAM.
// m0 = instruction cache, m1 = data cache. Exactly one burst is in flight at a time.
// Commands and data pass straight through in the cycle they arrive (no buffering).
// While IDLE, each owner holds a two-cycle slot. In phase 0 its busy is low. In
// phase 1 its busy is high, but a command that is registered late is still taken.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH      = 64,
    parameter int BURST_COUNT        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    burst_ram_arbiter_if.slave   m0,
    burst_ram_arbiter_if.slave   m1,
    burst_ram_arbiter_if.master  br,
    output logic [1:0]           dbg_state   // 0 = IDLE, 1 = READ, 2 = WRITE
);
    localparam int BEAT_W = $clog2(BURST_COUNT) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                owner, owner_nxt;
    logic                slot_phase, slot_phase_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;

    logic                              own_cmd;
    logic                              own_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]     own_addr;
    logic [DATA_BITWIDTH-1:0]          own_wr_data;
    logic [DATA_BITWIDTH/8-1:0]        own_data_mask;
    logic                              accept;
    logic                              free_slot;

    // Only the current owner's port is ever looked at, so the other master's
    // cmd_en cannot reach the RAM.
    assign own_cmd       = owner ? m1.cmd       : m0.cmd;
    assign own_cmd_en    = owner ? m1.cmd_en    : m0.cmd_en;
    assign own_addr      = owner ? m1.addr      : m0.addr;
    assign own_wr_data   = owner ? m1.wr_data   : m0.wr_data;
    assign own_data_mask = owner ? m1.data_mask : m0.data_mask;

    // rst gates accept so that no command leaks out while the block is held in reset.
    assign accept = !rst && (state == IDLE) && !br.busy && own_cmd_en;

    // Busy is low only in phase 0 of an idle slot, and only for the owner.
    assign free_slot = !rst && (state == IDLE) && !br.busy && !slot_phase;
    assign m0.busy   = !(free_slot && !owner);
    assign m1.busy   = !(free_slot &&  owner);

    // Read data fans out to both masters; only the owner's valid is raised.
    assign m0.rd_data       = br.rd_data;
    assign m1.rd_data       = br.rd_data;
    assign m0.rd_data_valid = br.rd_data_valid && !rst && (state == READ) && !owner;
    assign m1.rd_data_valid = br.rd_data_valid && !rst && (state == READ) &&  owner;

    assign dbg_state = state;

    // State register: arbitration state, slot owner, slot phase and beat count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            slot_phase <= 1'b0;
            beat       <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            slot_phase <= slot_phase_nxt;
            beat       <= beat_nxt;
        end
    end

    // Next-state logic and RAM-side routing
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        slot_phase_nxt = slot_phase;
        beat_nxt       = beat;
        br.cmd         = own_cmd;
        br.addr        = own_addr;
        br.wr_data     = own_wr_data;
        br.data_mask   = own_data_mask;
        br.cmd_en      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    br.cmd_en = 1'b1;
                    if (own_cmd) begin
                        // The command cycle already carried beat 0.
                        state_nxt = WRITE;
                        beat_nxt  = BEAT_W'(1);
                    end else begin
                        state_nxt = READ;
                        beat_nxt  = '0;
                    end
                end else if (slot_phase) begin
                    // The slot expired unused, so hand it to the other master.
                    owner_nxt      = !owner;
                    slot_phase_nxt = 1'b0;
                end else begin
                    slot_phase_nxt = 1'b1;
                end
            end

            READ: begin
                if (br.rd_data_valid) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt      = IDLE;
                        owner_nxt      = !owner;
                        slot_phase_nxt = 1'b0;
                        beat_nxt       = '0;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end

            WRITE: begin
                if (beat == LAST_BEAT) begin
                    state_nxt      = IDLE;
                    owner_nxt      = !owner;
                    slot_phase_nxt = 1'b0;
                    beat_nxt       = '0;
                end else begin
                    beat_nxt = beat + BEAT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
